arb4_rr: RTL and testbench

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_rr.sv | 106 ++++++++++
 tb/tb_arb4_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arb4_rr.sv
// Four-way round-robin arbiter with a per-owner hold limit; all outputs registered, grant 1 cycle after req.
// No backpressure: req is level-sensitive, ownership persists while req[owner] stays high (bounded by MAX_HOLD when contended).
module arb4_rr #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic [7:0] hold_cnt
);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic       vld_q, vld_d;
    logic [1:0] id_q, id_d;
    logic [3:0] others;

    // First set bit in the order base+1, base+2, base+3, base; lower offsets overwrite later ones.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        pick = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    // While OWNED, last_q is the current owner, so it also serves as the owner index.
    assign others = req & ~(4'b0001 << last_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
            grant_q <= 4'b0000;
            vld_q   <= 1'b0;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWNED;
                    last_d  = pick(req, last_q);
                    hold_d  = 8'd1;
                end
            end
            OWNED: begin
                if (req[last_q]) begin
                    if (hold_q < MAX_HOLD_C) begin
                        hold_d = hold_q + 8'd1;
                    end else begin
                        hold_d = 8'd1;
                        if (|others) last_d = pick(others, last_q);
                    end
                end else if (|others) begin
                    // Released owner is excluded, so a waiting requester always wins the handoff.
                    last_d = pick(others, last_q);
                    hold_d = 8'd1;
                end else begin
                    state_d = IDLE;
                    hold_d  = 8'd0;
                end
            end
        endcase
    end

    always_comb begin
        grant_d = 4'b0000;
        vld_d   = 1'b0;
        id_d    = 2'd0;
        if (state_d == OWNED) begin
            grant_d = 4'b0001 << last_d;
            vld_d   = 1'b1;
            id_d    = last_d;
        end
    end

    assign grant     = grant_q;
    assign gnt_valid = vld_q;
    assign gnt_id    = id_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Scoreboard bench for arb4_rr: directed vectors on MAX_HOLD=8 and MAX_HOLD=1 instances, then random fairness checks.
module tb_arb4_rr;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] h;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req8, req1;
    logic [3:0] grant8, grant1;
    logic       vld8, vld1;
    logic [1:0] id8, id1;
    logic [7:0] hold8, hold1;

    exp_t q8[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    logic rnd_on = 1'b0;

    always #5 clk = ~clk;

    arb4_rr #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .req(req8),
        .grant(grant8), .gnt_valid(vld8), .gnt_id(id8), .hold_cnt(hold8)
    );

    arb4_rr #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req1),
        .grant(grant1), .gnt_valid(vld1), .gnt_id(id1), .hold_cnt(hold1)
    );

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step8(input logic [3:0] r, input logic [3:0] g, input logic [7:0] h);
        exp_t e;
        @(negedge clk);
        req8 = r;
        e.g = g;
        e.h = h;
        q8.push_back(e);
    endtask

    task automatic step1(input logic [3:0] r, input logic [3:0] g, input logic [7:0] h);
        exp_t e;
        @(negedge clk);
        req1 = r;
        e.g = g;
        e.h = h;
        q1.push_back(e);
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("m8_grant", 32'(grant8), 32'(e.g));
                chk("m8_hold",  32'(hold8),  32'(e.h));
                chk("m8_valid", 32'(vld8),   32'(|e.g));
                chk("m8_id",    32'(id8),    32'(enc(e.g)));
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("m1_grant", 32'(grant1), 32'(e.g));
                chk("m1_hold",  32'(hold1),  32'(e.h));
                chk("m1_valid", 32'(vld1),   32'(|e.g));
                chk("m1_id",    32'(id1),    32'(enc(e.g)));
            end
        end
    end

    // Random-phase invariants and starvation bound (3 * MAX_HOLD = 24).
    initial begin
        int wc[4];
        for (int i = 0; i < 4; i++) wc[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) begin
                chk("rnd_onehot", 32'($countones(grant8) <= 1), 32'd1);
                chk("rnd_id",     32'(id8),  32'(enc(grant8)));
                chk("rnd_valid",  32'(vld8), 32'(|grant8));
                chk("rnd_nogrant_wo_req", 32'(grant8 & ~req8), 32'd0);
                chk("rnd_hold_max", 32'(hold8 <= 8'd8), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (req8[i] && !grant8[i]) wc[i]++;
                    else wc[i] = 0;
                    if (wc[i] > 24) begin
                        chk("rnd_wait_bound", 32'(wc[i]), 32'd24);
                        wc[i] = 0;
                    end
                end
            end else begin
                for (int i = 0; i < 4; i++) wc[i] = 0;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        req8    = 4'b0000;
        req1    = 4'b0000;
        #2;
        chk("rst_grant", 32'(grant8), 32'd0);
        chk("rst_valid", 32'(vld8),   32'd0);
        chk("rst_id",    32'(id8),    32'd0);
        chk("rst_hold",  32'(hold8),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // All requesting: 8 cycles each in order 0,1,2,3 then back to 0, no gaps.
        for (int k = 0; k < 36; k++)
            step8(4'b1111, 4'b0001 << ((k / 8) % 4), 8'((k % 8) + 1));
        step8(4'b0000, 4'b0000, 8'd0);

        // Lone requester: continuous grant, hold counts 1..8 then restarts.
        for (int k = 0; k < 20; k++)
            step8(4'b0100, 4'b0100, 8'((k % 8) + 1));
        step8(4'b0000, 4'b0000, 8'd0);

        // Owner 1 releases with 3 waiting: zero-idle handoff, then idle.
        step8(4'b0010, 4'b0010, 8'd1);
        step8(4'b1010, 4'b0010, 8'd2);
        step8(4'b1010, 4'b0010, 8'd3);
        step8(4'b1000, 4'b1000, 8'd1);
        step8(4'b0000, 4'b0000, 8'd0);

        // Forced rotation from owner 1 skips idle 2 and lands on 3; release of 3 then goes to 0.
        step8(4'b0010, 4'b0010, 8'd1);
        for (int k = 2; k <= 8; k++)
            step8(4'b1011, 4'b0010, 8'(k));
        step8(4'b1011, 4'b1000, 8'd1);
        step8(4'b1011, 4'b1000, 8'd2);
        step8(4'b0011, 4'b0001, 8'd1);
        step8(4'b0000, 4'b0000, 8'd0);

        // Asynchronous reset between edges while owner 1 holds.
        step8(4'b0010, 4'b0010, 8'd1);
        step8(4'b0010, 4'b0010, 8'd2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant8), 32'd0);
        chk("arst_valid", 32'(vld8),   32'd0);
        chk("arst_id",    32'(id8),    32'd0);
        chk("arst_hold",  32'(hold8),  32'd0);
        #1;
        reset_n = 1'b1;
        step8(4'b1010, 4'b0010, 8'd1);
        step8(4'b0000, 4'b0000, 8'd0);

        // MAX_HOLD = 1: alternate every cycle; lone requester keeps grant with hold 1.
        for (int k = 0; k < 6; k++)
            step1(4'b0101, (k % 2 == 0) ? 4'b0001 : 4'b0100, 8'd1);
        step1(4'b0100, 4'b0100, 8'd1);
        step1(4'b0100, 4'b0100, 8'd1);
        step1(4'b0000, 4'b0000, 8'd0);

        // Random sticky requests for the fairness and invariant checks.
        @(negedge clk);
        rnd_on = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) req8[i] = ~req8[i];
        end
        @(negedge clk);
        rnd_on = 1'b0;
        req8   = 4'b0000;

        for (int k = 0; k < 20 && (q8.size() != 0 || q1.size() != 0); k++)
            @(posedge clk);
        #2;
        chk("drain", 32'(q8.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
